// File: rtl/iomux_pkg.sv
// ============================================================================
// Module : iomux_pkg
// Brief  : Shared types and constants for the pad-mux function controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iomux_pkg;

    localparam int   c_npins_default = 20;

    localparam logic c_addr_fn       = 1'b0;
    localparam logic c_addr_lock     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RELEASE = 2'd2
    } iomux_state_e;

endpackage

`default_nettype wire

// File: rtl/iomux_settle_cnt.sv
// ============================================================================
// Module : iomux_settle_cnt
// Brief  : OE-blanking down-counter; load arms a SETTLE-cycle phase.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iomux_settle_cnt
    import iomux_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_load,
    input  logic i_tick,
    output logic o_zero
);

    localparam int c_w = $clog2(SETTLE + 1);

    logic [c_w-1:0] r_cnt;

    // Loading SETTLE-1 makes a phase last SETTLE cycles including the zero cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_w'(SETTLE - 1);
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_w'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/iomux_ctrl.sv
// ============================================================================
// Module : iomux_ctrl
// Brief  : Glitch-free pad function switching with OE blanking and lock bits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iomux_ctrl
    import iomux_pkg::*;
#(
    parameter int NPINS  = c_npins_default,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             wr_addr,
    input  logic [NPINS-1:0] wr_data,
    input  logic             rd_addr,
    output logic [NPINS-1:0] rd_data,
    output logic [NPINS-1:0] gpio_fn,
    output logic [NPINS-1:0] oe_block,
    output logic             busy,
    output logic             err
);

    iomux_state_e     r_state;
    iomux_state_e     w_state_nxt;

    logic [NPINS-1:0] r_fn;
    logic [NPINS-1:0] r_lock;
    logic [NPINS-1:0] r_diff;
    logic [NPINS-1:0] r_rd;
    logic             r_err;
    logic             r_rdy_en;

    logic             w_accept;
    logic             w_fn_wr;
    logic             w_lock_wr;
    logic [NPINS-1:0] w_delta;
    logic [NPINS-1:0] w_diff;
    logic             w_cnt_zero;
    logic             w_load;
    logic             w_tick;
    logic             w_apply;

    assign w_accept  = wr_valid & wr_ready;
    assign w_fn_wr   = w_accept & (wr_addr == c_addr_fn);
    assign w_lock_wr = w_accept & (wr_addr == c_addr_lock);
    assign w_delta   = wr_data ^ r_fn;
    assign w_diff    = w_delta & ~r_lock;
    assign w_apply   = (r_state == ST_DRAIN) & w_cnt_zero;

    iomux_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_load),
        .i_tick (w_tick),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tick      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_fn_wr && (w_diff != '0)) begin
                    w_state_nxt = ST_DRAIN;
                    w_load      = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_RELEASE;
                    w_load      = 1'b1;
                end else begin
                    w_tick = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tick = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The function register only flips at the DRAIN/RELEASE boundary, so the
    // changed pads are blanked both before and after the mux select moves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fn     <= '0;
            r_lock   <= '0;
            r_diff   <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            r_err    <= w_fn_wr & (|(w_delta & r_lock));
            r_rd     <= (rd_addr == c_addr_lock) ? r_lock : r_fn;
            if (w_fn_wr) begin
                r_diff <= w_diff;
            end
            if (w_lock_wr) begin
                r_lock <= r_lock | wr_data;
            end
            if (w_apply) begin
                r_fn <= r_fn ^ r_diff;
            end
        end
    end

    assign wr_ready = r_rdy_en & (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign oe_block = busy ? r_diff : '0;
    assign gpio_fn  = r_fn;
    assign rd_data  = r_rd;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_iomux_ctrl.sv
// ============================================================================
// Module : tb_iomux_ctrl
// Brief  : Directed and randomized checks of iomux_ctrl against a timeline model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_iomux_ctrl;

    localparam int NPINS  = 20;
    localparam int SETTLE = 4;

    logic             clk      = 1'b0;
    logic             rstn     = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_addr  = 1'b0;
    logic [NPINS-1:0] wr_data  = '0;
    logic             rd_addr  = 1'b0;
    logic             wr_ready;
    logic [NPINS-1:0] rd_data;
    logic [NPINS-1:0] gpio_fn;
    logic [NPINS-1:0] oe_block;
    logic             busy;
    logic             err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iomux_ctrl #(
        .NPINS  (NPINS),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .gpio_fn  (gpio_fn),
        .oe_block (oe_block),
        .busy     (busy),
        .err      (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a switch accepted at edge E blanks its pads for edges
    // E..E+2S-1 and flips the function at edge E+S.
    logic [NPINS-1:0] m_fn    = '0;
    logic [NPINS-1:0] m_lock  = '0;
    logic [NPINS-1:0] m_diff  = '0;
    logic [NPINS-1:0] m_rd    = '0;
    logic             m_busy  = 1'b0;
    logic             m_err   = 1'b0;
    logic             m_rdy   = 1'b0;
    int               m_n     = 0;
    int               m_start = 0;

    always @(posedge clk or negedge rstn) begin : ref_model
        logic             rdy;
        logic [NPINS-1:0] dlt;
        logic [NPINS-1:0] fpre;
        logic [NPINS-1:0] lpre;
        if (!rstn) begin
            m_fn   = '0;
            m_lock = '0;
            m_diff = '0;
            m_rd   = '0;
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_rdy  = 1'b0;
        end else begin
            rdy  = m_rdy && !m_busy;
            fpre = m_fn;
            lpre = m_lock;
            m_n++;
            m_err = 1'b0;
            m_rd  = rd_addr ? lpre : fpre;
            if (m_busy) begin
                if (m_n == m_start + SETTLE)   m_fn = m_fn ^ m_diff;
                if (m_n == m_start + 2*SETTLE) m_busy = 1'b0;
            end
            if (rdy && wr_valid) begin
                if (wr_addr) begin
                    m_lock = lpre | wr_data;
                end else begin
                    dlt   = wr_data ^ fpre;
                    m_err = |(dlt & lpre);
                    if ((dlt & ~lpre) != '0) begin
                        m_busy  = 1'b1;
                        m_diff  = dlt & ~lpre;
                        m_start = m_n;
                    end
                end
            end
            m_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, (m_rdy && !m_busy)});
        chk("gpio_fn",  {12'b0, gpio_fn},  {12'b0, m_fn});
        chk("oe_block", {12'b0, oe_block}, {12'b0, (m_busy ? m_diff : 20'h0)});
        chk("busy",     {31'b0, busy},     {31'b0, m_busy});
        chk("err",      {31'b0, err},      {31'b0, m_err});
        chk("rd_data",  {12'b0, rd_data},  {12'b0, m_rd});
    end

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic do_write(input logic a, input logic [NPINS-1:0] d, output int waited);
        waited   = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("write_accept_timeout", {31'b0, wr_ready}, 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        int w;
        int w2;
        int r;
        logic [NPINS-1:0] bitv;

        // Reset and release
        repeat (3) @(negedge clk);
        chk("rst_gpio", {12'b0, gpio_fn}, 32'h0);
        chk("rst_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_oe", {12'b0, oe_block}, 32'h0);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'b0, wr_ready}, 32'd1);
        chk("rel_gpio", {12'b0, gpio_fn}, 32'h0);

        // Basic switch of pads 0 and 1
        do_write(1'b0, 20'h00003, w);
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) @(negedge clk);
            chk("sw_oe",    {12'b0, oe_block}, (i <= 8) ? 32'h3 : 32'h0);
            chk("sw_gpio",  {12'b0, gpio_fn},  (i >= 5) ? 32'h3 : 32'h0);
            chk("sw_busy",  {31'b0, busy},     (i <= 8) ? 32'd1 : 32'd0);
            chk("sw_ready", {31'b0, wr_ready}, (i == 9) ? 32'd1 : 32'd0);
        end

        // Rewrite of the current value: no sequence, back-to-back accept
        do_write(1'b0, 20'h00003, w);
        chk("same_busy", {31'b0, busy}, 32'd0);
        chk("same_oe", {12'b0, oe_block}, 32'h0);
        chk("same_ready", {31'b0, wr_ready}, 32'd1);
        do_write(1'b0, 20'h00003, w);
        chk("same_wait", w, 32'd0);

        // Lock pad 0, then try to clear both pads
        do_write(1'b1, 20'h00001, w);
        do_write(1'b0, 20'h00000, w);
        chk("lock_err", {31'b0, err}, 32'd1);
        chk("lock_oe", {12'b0, oe_block}, 32'h2);
        rd_addr = 1'b1;
        @(negedge clk);
        chk("lock_err_pulse", {31'b0, err}, 32'd0);
        chk("lock_rd", {12'b0, rd_data}, 32'h1);
        rd_addr = 1'b0;
        @(negedge clk);
        chk("rd_pre_switch", {12'b0, rd_data}, 32'h3);
        repeat (6) @(negedge clk);
        chk("lock_gpio_end", {12'b0, gpio_fn}, 32'h1);
        chk("lock_oe_end", {12'b0, oe_block}, 32'h0);

        // Request held during a busy window
        do_write(1'b0, 20'h00003, w);
        do_write(1'b0, 20'h00000, w2);
        chk("held_wait", w2, 32'd8);
        chk("held_busy", {31'b0, busy}, 32'd1);
        chk("held_oe", {12'b0, oe_block}, 32'h2);
        repeat (8) @(negedge clk);
        chk("held_gpio", {12'b0, gpio_fn}, 32'h1);

        // Reset in the middle of a switch
        do_write(1'b0, 20'h000F1, w);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_gpio", {12'b0, gpio_fn}, 32'h0);
        chk("abort_oe", {12'b0, oe_block}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        rd_addr = 1'b1;
        @(negedge clk);
        chk("abort_lock", {12'b0, rd_data}, 32'h0);
        rd_addr = 1'b0;
        do_write(1'b0, 20'h00001, w);
        chk("abort_unlocked_oe", {12'b0, oe_block}, 32'h1);
        repeat (8) @(negedge clk);

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            repeat ($urandom_range(0, 3)) begin
                rd_addr = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if ($urandom_range(0, 49) == 0) begin
                #2 rstn = 1'b0;
                repeat (2) @(negedge clk);
                #2 rstn = 1'b1;
                @(negedge clk);
            end
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                bitv = 20'd1 << $urandom_range(0, NPINS-1);
                do_write(1'b1, bitv, w);
            end else if (r < 3) begin
                do_write(1'b0, m_fn, w);
            end else begin
                do_write(1'b0, 20'($urandom), w);
            end
        end
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iomux_ctrl.md
IOMUX_CTRL -- requirements
Module: iomux_ctrl

Interface
REQ-001 SHALL have parameter NPINS, default 20, meaning the number of muxed pads.
REQ-002 SHALL have parameter SETTLE, default 4, meaning the OE-blanking cycles before and after a function switch; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port wr_valid, input, 1 bit: write request.
REQ-006 SHALL have port wr_ready, output, 1 bit: controller accepts a write this cycle.
REQ-007 SHALL have port wr_addr, input, 1 bit: target register, 0=FN, 1=LOCK.
REQ-008 SHALL have port wr_data, input, NPINS bits: write value.
REQ-009 SHALL have port rd_addr, input, 1 bit: read select, 0=FN, 1=LOCK.
REQ-010 SHALL have port rd_data, output, NPINS bits: registered read data.
REQ-011 SHALL have port gpio_fn, output, NPINS bits: per-pad select driven to the mux (0=GPIO, 1=peripheral function).
REQ-012 SHALL have port oe_block, output, NPINS bits: pads whose pad output-enable the top level forces low.
REQ-013 SHALL have port busy, output, 1 bit: a switch sequence is in progress.
REQ-014 SHALL have port err, output, 1 bit: one-cycle pulse flagging a write to locked pads.

Function
REQ-015 SHALL accept a write on a clk edge where wr_valid and wr_ready are both 1; wr_ready SHALL equal 1 only in state IDLE.
REQ-016 SHALL implement states IDLE, DRAIN and RELEASE, with a down-counter of width clog2(SETTLE+1).
REQ-017 SHALL, on an accepted FN write, compute diff = (wr_data XOR fn_reg) AND NOT lock_reg and capture it in a register.
REQ-018 SHALL remain in IDLE with no output change other than err when diff is 0.
REQ-019 SHALL, for an FN write accepted at edge k with nonzero diff, enter DRAIN at k+1 with oe_block=diff, busy=1 and wr_ready=0, and remain there SETTLE cycles.
REQ-020 SHALL, on the edge ending DRAIN, apply fn_reg <= fn_reg XOR diff and enter RELEASE with oe_block still equal to diff, remaining there SETTLE cycles.
REQ-021 SHALL, on the edge ending RELEASE, return to IDLE with oe_block=0 and busy=0; the total busy window is exactly 2*SETTLE cycles.
REQ-022 SHALL drive gpio_fn directly from fn_reg, so that gpio_fn never changes while a changed pad has oe_block=0.
REQ-023 SHALL keep oe_block at 0 on pads outside diff at all times.
REQ-024 SHALL assert err for exactly one cycle (k+1) when an accepted FN write differs from fn_reg on any pad with lock_reg=1; those pads SHALL stay unchanged while unlocked pads proceed per REQ-019..021.
REQ-025 SHALL make an accepted LOCK write apply lock_reg <= lock_reg OR wr_data at k+1, with no sequence; lock bits SHALL be clearable only by reset.
REQ-026 SHALL register rd_data one cycle after rd_addr; a read of FN during a sequence SHALL return the pre-switch value until the REQ-020 edge.
REQ-027 SHALL ignore wr_valid while wr_ready=0; the requester holds its request.

Reset
REQ-028 SHALL, while rstn=0, asynchronously force state=IDLE, fn_reg=0 (all GPIO), lock_reg=0, diff=0, counter=0, oe_block=0, busy=0, err=0 and rd_data=0.
REQ-029 SHALL keep wr_ready=0 while rstn=0 and drive it to 1 on the first cycle after release.
REQ-030 SHALL abort any in-progress sequence when reset asserts; FN returns to 0 and no partial switch survives.

Structure
REQ-031 SHALL define the state encoding, the register addresses (FN=0, LOCK=1) and the default NPINS in a shared package (iomux_pkg) also used by the top level.
REQ-032 SHALL implement the blanking counter as a single sub-module, iomux_settle_cnt, with load, tick-down and zero-flag.
REQ-033 SHALL leave the pad mux combinational and outside this block, with oe_block ANDed into pad_oe at the top level.

Verification (SETTLE=4, NPINS=20)
REQ-034 SHALL cover: reset release -> gpio_fn=0x00000, oe_block=0, wr_ready=1 one cycle later.
REQ-035 SHALL cover: FN write 0x00003 at edge k -> oe_block=0x00003 over k+1..k+8, gpio_fn=0x00003 from k+5, busy high for 8 cycles, wr_ready high again at k+9.
REQ-036 SHALL cover: LOCK write 0x00001 then FN write 0x00000 -> err pulse at k+1, gpio_fn ends at 0x00001, oe_block=0x00002 only.
REQ-037 SHALL cover: FN write equal to the current value -> busy stays 0, oe_block stays 0, next write accepted at k+1.
REQ-038 SHALL cover: wr_valid held high during busy -> second write accepted only at the first IDLE cycle, after which its sequence starts.
REQ-039 SHALL cover: rstn low at cycle k+3 of REQ-035 -> immediately gpio_fn=0, oe_block=0, lock_reg=0.
